// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS-subset control unit.
// State encodings are fixed because they are visible on the debug port.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        IEXEC  = 4'd11,
        IWB    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       bne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       link;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [2:0] aluop;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // Dispatch out of DECODE; unknown opcodes fall back to FETCH.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:            decode_next = MEMADR;
            OP_RTYPE:                decode_next = EXEC;
            OP_BEQ, OP_BNE:          decode_next = BRANCH;
            OP_J, OP_JAL:            decode_next = JUMP;
            OP_ADDI, OP_ORI, OP_LUI: decode_next = IEXEC;
            default:                 decode_next = FETCH;
        endcase
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        op_legal = (decode_next(op) != FETCH);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control-unit to datapath/memory bundle: IR opcode and memory ready in,
// datapath strobes and selects out.
interface mc_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] aluop;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, bne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, link, alu_src_a,
               alu_src_b, zero_ext, aluop, pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, bne, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, link, alu_src_a,
               alu_src_b, zero_ext, aluop, pc_source, illegal_op, state
    );
endinterface

// File: rtl/mc_outdec.sv
// Moore output decode: pure function of the current state, with opcode and
// mem_ready qualifying only the few outputs that depend on them.
module mc_outdec
    import mc_pkg::*;
(
    input  state_t     st,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      c
);

    always_comb begin
        c = '0;
        case (st)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.aluop     = ALU_ADD;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            DECODE: begin
                c.alu_src_b  = SRCB_BROFF;
                c.aluop      = ALU_ADD;
                c.illegal_op = ~op_legal(opcode);
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALU_ADD;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.aluop     = ALU_FUNCT;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.aluop         = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_ALUOUT;
                c.bne           = (opcode == OP_BNE);
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_JUMP;
                c.reg_write = (opcode == OP_JAL);
                c.link      = (opcode == OP_JAL);
            end
            IEXEC, IWB: begin
                // ALU op and extension stay put into IWB so ALUOut is stable at write-back
                if (st == IEXEC) begin
                    c.alu_src_a = 1'b1;
                    c.alu_src_b = SRCB_IMM;
                end else begin
                    c.reg_write = 1'b1;
                end
                case (opcode)
                    OP_ORI:  begin c.aluop = ALU_OR;  c.zero_ext = 1'b1; end
                    OP_LUI:  begin c.aluop = ALU_LUI; c.zero_ext = 1'b1; end
                    default: begin c.aluop = ALU_ADD; c.zero_ext = 1'b0; end
                endcase
            end
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM: state register and next-state logic; outputs are
// decoded combinationally from the state so reset clears them immediately.
module mc_control
    import mc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mc_control_if.master  bus
);

    state_t st;
    ctrl_t  c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE:    st <= FETCH;
                FETCH:   st <= bus.mem_ready ? DECODE : FETCH;
                DECODE:  st <= decode_next(bus.opcode);
                MEMADR:  st <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   st <= bus.mem_ready ? MEMWB : MEMRD;
                MEMWB:   st <= FETCH;
                MEMWR:   st <= bus.mem_ready ? FETCH : MEMWR;
                EXEC:    st <= ALUWB;
                ALUWB:   st <= FETCH;
                BRANCH:  st <= FETCH;
                JUMP:    st <= FETCH;
                IEXEC:   st <= IWB;
                IWB:     st <= FETCH;
                default: st <= IDLE;
            endcase
        end
    end

    mc_outdec u_outdec (
        .st        (st),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .c         (c)
    );

    assign bus.pc_write      = c.pc_write;
    assign bus.pc_write_cond = c.pc_write_cond;
    assign bus.bne           = c.bne;
    assign bus.iord          = c.iord;
    assign bus.mem_read      = c.mem_read;
    assign bus.mem_write     = c.mem_write;
    assign bus.ir_write      = c.ir_write;
    assign bus.mem_to_reg    = c.mem_to_reg;
    assign bus.reg_dst       = c.reg_dst;
    assign bus.reg_write     = c.reg_write;
    assign bus.link          = c.link;
    assign bus.alu_src_a     = c.alu_src_a;
    assign bus.alu_src_b     = c.alu_src_b;
    assign bus.zero_ext      = c.zero_ext;
    assign bus.aluop         = c.aluop;
    assign bus.pc_source     = c.pc_source;
    assign bus.illegal_op    = c.illegal_op;
    assign bus.state         = st;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle vector table of expected outputs,
// plus reset-at-start and reset-during-write sequences.
module tb_mc_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, link, srca;
        logic [1:0] srcb;
        logic       zext;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam out_t O_IDLE    = '{default:'0};
    localparam out_t O_FETCH_W = '{st:4'd1, mrd:1'b1, srcb:2'b01, default:'0};
    localparam out_t O_FETCH_R = '{st:4'd1, mrd:1'b1, srcb:2'b01, pcw:1'b1, irw:1'b1, default:'0};
    localparam out_t O_DEC     = '{st:4'd2, srcb:2'b11, default:'0};
    localparam out_t O_DEC_ILL = '{st:4'd2, srcb:2'b11, ill:1'b1, default:'0};
    localparam out_t O_MEMADR  = '{st:4'd3, srca:1'b1, srcb:2'b10, default:'0};
    localparam out_t O_MEMRD   = '{st:4'd4, mrd:1'b1, iord:1'b1, default:'0};
    localparam out_t O_MEMWB   = '{st:4'd5, rw:1'b1, m2r:1'b1, default:'0};
    localparam out_t O_MEMWR   = '{st:4'd6, mwr:1'b1, iord:1'b1, default:'0};
    localparam out_t O_EXEC    = '{st:4'd7, srca:1'b1, aluop:3'b111, default:'0};
    localparam out_t O_ALUWB   = '{st:4'd8, rw:1'b1, rdst:1'b1, default:'0};
    localparam out_t O_BEQ     = '{st:4'd9, srca:1'b1, aluop:3'b001, pcwc:1'b1, pcsrc:2'b01, default:'0};
    localparam out_t O_BNE     = '{st:4'd9, srca:1'b1, aluop:3'b001, pcwc:1'b1, pcsrc:2'b01, bne:1'b1, default:'0};
    localparam out_t O_J       = '{st:4'd10, pcw:1'b1, pcsrc:2'b10, default:'0};
    localparam out_t O_JAL     = '{st:4'd10, pcw:1'b1, pcsrc:2'b10, rw:1'b1, link:1'b1, default:'0};
    localparam out_t O_ADDI_X  = '{st:4'd11, srca:1'b1, srcb:2'b10, default:'0};
    localparam out_t O_ORI_X   = '{st:4'd11, srca:1'b1, srcb:2'b10, aluop:3'b011, zext:1'b1, default:'0};
    localparam out_t O_LUI_X   = '{st:4'd11, srca:1'b1, srcb:2'b10, aluop:3'b100, zext:1'b1, default:'0};
    localparam out_t O_ADDI_WB = '{st:4'd12, rw:1'b1, default:'0};
    localparam out_t O_ORI_WB  = '{st:4'd12, rw:1'b1, aluop:3'b011, zext:1'b1, default:'0};
    localparam out_t O_LUI_WB  = '{st:4'd12, rw:1'b1, aluop:3'b100, zext:1'b1, default:'0};

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    mc_control_if bus ();

    mc_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.st    = bus.state;
        o.pcw   = bus.pc_write;
        o.pcwc  = bus.pc_write_cond;
        o.bne   = bus.bne;
        o.iord  = bus.iord;
        o.mrd   = bus.mem_read;
        o.mwr   = bus.mem_write;
        o.irw   = bus.ir_write;
        o.m2r   = bus.mem_to_reg;
        o.rdst  = bus.reg_dst;
        o.rw    = bus.reg_write;
        o.link  = bus.link;
        o.srca  = bus.alu_src_a;
        o.srcb  = bus.alu_src_b;
        o.zext  = bus.zero_ext;
        o.aluop = bus.aluop;
        o.pcsrc = bus.pc_source;
        o.ill   = bus.illegal_op;
        return o;
    endfunction

    task automatic chk(input string name, input out_t exp);
        out_t act;
        act = sample();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     name, act, act.st, exp, exp.st);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input out_t e);
        vec_t v;
        v.op = op; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic [5:0] op, input logic rdy, input string name, input out_t e);
        @(negedge clk);
        bus.opcode = op; bus.mem_ready = rdy;
        #1 chk(name, e);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = 6'b0;
        bus.mem_ready = 1'b0;

        // lw, no stalls
        add(6'b100011, 1, O_FETCH_R); add(6'b100011, 1, O_DEC);
        add(6'b100011, 1, O_MEMADR);  add(6'b100011, 1, O_MEMRD);
        add(6'b100011, 1, O_MEMWB);
        // fetch stall x3, then sw with one write stall
        add(6'b101011, 0, O_FETCH_W); add(6'b101011, 0, O_FETCH_W);
        add(6'b101011, 0, O_FETCH_W); add(6'b101011, 1, O_FETCH_R);
        add(6'b101011, 1, O_DEC);     add(6'b101011, 1, O_MEMADR);
        add(6'b101011, 0, O_MEMWR);   add(6'b101011, 1, O_MEMWR);
        // R-type
        add(6'b000000, 1, O_FETCH_R); add(6'b000000, 1, O_DEC);
        add(6'b000000, 1, O_EXEC);    add(6'b000000, 1, O_ALUWB);
        // beq, bne
        add(6'b000100, 1, O_FETCH_R); add(6'b000100, 1, O_DEC); add(6'b000100, 1, O_BEQ);
        add(6'b000101, 1, O_FETCH_R); add(6'b000101, 1, O_DEC); add(6'b000101, 1, O_BNE);
        // j, jal
        add(6'b000010, 1, O_FETCH_R); add(6'b000010, 1, O_DEC); add(6'b000010, 1, O_J);
        add(6'b000011, 1, O_FETCH_R); add(6'b000011, 1, O_DEC); add(6'b000011, 1, O_JAL);
        // addi, ori, lui
        add(6'b001000, 1, O_FETCH_R); add(6'b001000, 1, O_DEC);
        add(6'b001000, 1, O_ADDI_X);  add(6'b001000, 1, O_ADDI_WB);
        add(6'b001101, 1, O_FETCH_R); add(6'b001101, 1, O_DEC);
        add(6'b001101, 1, O_ORI_X);   add(6'b001101, 1, O_ORI_WB);
        add(6'b001111, 1, O_FETCH_R); add(6'b001111, 1, O_DEC);
        add(6'b001111, 1, O_LUI_X);   add(6'b001111, 1, O_LUI_WB);
        // illegal opcodes: two cycles, no writes
        add(6'b111111, 1, O_FETCH_R); add(6'b111111, 1, O_DEC_ILL);
        add(6'b001001, 1, O_FETCH_R); add(6'b001001, 1, O_DEC_ILL);
        // lw with two read stalls
        add(6'b100011, 1, O_FETCH_R); add(6'b100011, 1, O_DEC);
        add(6'b100011, 1, O_MEMADR);  add(6'b100011, 0, O_MEMRD);
        add(6'b100011, 0, O_MEMRD);   add(6'b100011, 1, O_MEMRD);
        add(6'b100011, 1, O_MEMWB);   add(6'b000010, 0, O_FETCH_W);

        #2 chk("reset_state", O_IDLE);
        @(negedge clk);
        #1 chk("reset_held", O_IDLE);

        // Release reset: one IDLE cycle, then the table runs cycle by cycle
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_reset_idle", O_IDLE);
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.opcode = vecs[i].op;
            bus.mem_ready = vecs[i].rdy;
            #1 chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset in the middle of a stalled write
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("sync_point_reset", O_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_idle", O_IDLE);
        step(6'b101011, 1, "wr_fetch", O_FETCH_R);
        step(6'b101011, 1, "wr_dec", O_DEC);
        step(6'b101011, 1, "wr_adr", O_MEMADR);
        step(6'b101011, 0, "wr_stall", O_MEMWR);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_mem_write", O_IDLE);
        @(negedge clk);
        #1 chk("rst_low_idle", O_IDLE);
        rst_n = 1'b1;
        #1 chk("release_idle", O_IDLE);
        step(6'b101011, 0, "release_fetch", O_FETCH_W);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
